// File: rtl/sram_frame_reader_if.sv
// sram_frame_reader_if: bus bundle between the SRAM frame reader and its surroundings.
//  Frame handshake : frameReady, frameWords (in), busy, frameDone (out)
//  SRAM port 1     : SRADDR, SROE_N, SRWE_N (out), SRDATA (in)
//  UART handshake  : readData, txStart (out), txStatus (in)
// master = the reader block; slave = environment (writer side, SRAM, UART).
interface sram_frame_reader_if #(
  parameter int unsigned ADDR_W = 18
);
  logic              frameReady;
  logic [ADDR_W-1:0] frameWords;
  logic              busy;
  logic              frameDone;
  logic [ADDR_W-1:0] SRADDR;
  logic              SROE_N;
  logic              SRWE_N;
  logic [15:0]       SRDATA;
  logic [7:0]        readData;
  logic              txStart;
  logic              txStatus;

  modport master (
    input  frameReady, frameWords, SRDATA, txStatus,
    output busy, frameDone, SRADDR, SROE_N, SRWE_N, readData, txStart
  );

  modport slave (
    output frameReady, frameWords, SRDATA, txStatus,
    input  busy, frameDone, SRADDR, SROE_N, SRWE_N, readData, txStart
  );
endinterface

// File: rtl/sram_frame_reader.sv
// sram_frame_reader: fetches a completed camera frame from SRAM word by word and hands each
// 16-bit word to the UART transmitter as two bytes over the txStart/txStatus handshake.
//  readClk   : system/UART-side clock
//  readRst_n : asynchronous active-low reset; aborts a frame in progress
//  bus       : sram_frame_reader_if.master (frame handshake, SRAM read port, UART handshake)
// Parameters: ADDR_W (word-address width), RD_WAIT (cycles from SROE_N low to SRDATA
// sample, >= 1), HI_FIRST (1: SRDATA[15:8] sent first).
// Optional feature: define FRAME_HEADER_EN to send sync bytes A5, 5A before each frame.
module sram_frame_reader #(
  parameter int unsigned ADDR_W   = 18,
  parameter int unsigned RD_WAIT  = 2,
  parameter bit          HI_FIRST = 1'b1
) (
  input logic                 readClk,
  input logic                 readRst_n,
  sram_frame_reader_if.master bus
);

  localparam int unsigned CntW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

  typedef enum logic [2:0] {
    StIdle,
`ifdef FRAME_HEADER_EN
    StHdr0,
    StHdr1,
`endif
    StFetch,
    StWait,
    StSend0,
    StSend1,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [15:0]       word_q, word_d;
  logic [7:0]        data_q, data_d;
  logic              oe_n_q, oe_n_d;
  logic              tx_q, tx_d;

  logic [7:0] byte0, byte1;
  logic       tx_ok;
  logic       last_word;

  assign byte0 = HI_FIRST ? word_q[15:8] : word_q[7:0];
  assign byte1 = HI_FIRST ? word_q[7:0]  : word_q[15:8];
  // txStatus still shows the old idle level during our own txStart cycle, so ignore it then.
  assign tx_ok = !tx_q && !bus.txStatus;
  assign last_word = (addr_q == (words_q - ADDR_W'(1)));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    words_d = words_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    data_d  = data_q;
    oe_n_d  = oe_n_q;
    tx_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.frameReady) begin
          words_d = bus.frameWords;
          addr_d  = '0;
`ifdef FRAME_HEADER_EN
          state_d = StHdr0;
`else
          state_d = (bus.frameWords == '0) ? StDone : StFetch;
`endif
        end
      end
`ifdef FRAME_HEADER_EN
      StHdr0: begin
        if (tx_ok) begin
          tx_d    = 1'b1;
          data_d  = 8'hA5;
          state_d = StHdr1;
        end
      end
      StHdr1: begin
        if (tx_ok) begin
          tx_d    = 1'b1;
          data_d  = 8'h5A;
          state_d = (words_q == '0) ? StDone : StFetch;
        end
      end
`endif
      StFetch: begin
        oe_n_d  = 1'b0;
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == CntW'(RD_WAIT - 1)) begin
          word_d  = bus.SRDATA;
          oe_n_d  = 1'b1;
          state_d = StSend0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSend0: begin
        if (tx_ok) begin
          tx_d    = 1'b1;
          data_d  = byte0;
          state_d = StSend1;
        end
      end
      StSend1: begin
        if (tx_ok) begin
          tx_d   = 1'b1;
          data_d = byte1;
          if (last_word) begin
            addr_d  = '0;
            state_d = StDone;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        addr_d = '0;
        // Hold off until the final txStart has been seen so frameDone follows the last byte.
        if (!tx_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge readClk or negedge readRst_n) begin
    if (!readRst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      words_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      oe_n_q  <= 1'b1;
      tx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      data_q  <= data_d;
      oe_n_q  <= oe_n_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.SRADDR    = addr_q;
  assign bus.SROE_N    = oe_n_q;
  assign bus.SRWE_N    = 1'b1;
  assign bus.readData  = data_q;
  assign bus.txStart   = tx_q;
  assign bus.frameDone = (state_q == StDone) && !tx_q;
  assign bus.busy      = (state_q != StIdle) && !bus.frameDone;

endmodule

// File: tb/tb_sram_frame_reader.sv
// tb_sram_frame_reader: scoreboard bench for sram_frame_reader with an SRAM array model,
// a UART model that stays busy a programmable number of cycles, and directed plus
// randomized frames. Expected bytes are queued at frame start; a negedge monitor pops them.
module tb_sram_frame_reader;
  localparam int unsigned ADDR_W   = 18;
  localparam int unsigned RD_WAIT  = 2;
  localparam bit          HI_FIRST = 1'b1;
`ifdef FRAME_HEADER_EN
  localparam int unsigned HDR = 2;
`else
  localparam int unsigned HDR = 0;
`endif

  logic readClk = 1'b0;
  logic readRst_n = 1'b1;
  always #5 readClk = ~readClk;

  sram_frame_reader_if #(.ADDR_W(ADDR_W)) bus ();

  sram_frame_reader #(
    .ADDR_W  (ADDR_W),
    .RD_WAIT (RD_WAIT),
    .HI_FIRST(HI_FIRST)
  ) dut (
    .readClk  (readClk),
    .readRst_n(readRst_n),
    .bus      (bus)
  );

  // SRAM model: data only driven while output enable is active.
  logic [15:0] mem [0:63];
  assign bus.SRDATA = bus.SROE_N ? 16'hDEAD : mem[bus.SRADDR[5:0]];

  // UART model: busy uart_len cycles starting the cycle after txStart.
  int unsigned uart_len = 10;
  int unsigned uart_cnt;
  logic        hold_busy = 1'b0;
  always @(posedge readClk or negedge readRst_n) begin
    if (!readRst_n)       uart_cnt <= 0;
    else if (bus.txStart) uart_cnt <= uart_len;
    else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
  end
  assign bus.txStatus = (uart_cnt != 0) || hold_busy;

  int cyc = 0;
  always @(posedge readClk) cyc++;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [7:0]  exp_q[$];
  int unsigned cur_words = 0;
  int          tx_count = 0;
  int          tx_before = 0;
  int          oe_low_count = 0;
  logic        armed = 1'b0;
  logic        prev_tx = 1'b0;

  // Monitor: scoreboard pop, address range and handshake rules.
  always @(negedge readClk) begin
    if (readRst_n) begin
      if (bus.txStatus) armed = 1'b0;
      if (!bus.SROE_N) begin
        oe_low_count++;
        check("sraddr_range", 32'(bus.SRADDR < ADDR_W'(cur_words)), 1);
      end
      if (bus.txStart) begin
        tx_count++;
        check("tx_pulse_width", 32'(prev_tx), 0);
        check("tx_handshake_gap", 32'(armed), 0);
        armed = 1'b1;
        check("byte_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("byte_value", 32'(bus.readData), 32'(exp_q.pop_front()));
      end
      if (bus.frameDone) check("bytes_left_at_done", 32'(exp_q.size()), 0);
      prev_tx = bus.txStart;
    end else begin
      armed   = 1'b0;
      prev_tx = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge readClk);
  endtask

  // Reference model: header, then each word split by the configured byte order.
  task automatic start_frame(input int unsigned n);
    cur_words = n;
    if (HDR != 0) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
    end
    for (int w = 0; w < int'(n); w++) begin
      if (HI_FIRST) begin
        exp_q.push_back(mem[w][15:8]);
        exp_q.push_back(mem[w][7:0]);
      end else begin
        exp_q.push_back(mem[w][7:0]);
        exp_q.push_back(mem[w][15:8]);
      end
    end
    tx_before = tx_count;
    bus.frameWords = ADDR_W'(n);
    bus.frameReady = 1'b1;
    tick(1);
    check("accept", 32'(bus.busy | bus.frameDone), 1);
    bus.frameReady = 1'b0;
  endtask

  task automatic finish_frame(input int unsigned n, input bit toggle);
    int i = 0;
    while (!bus.frameDone && i < 5000) begin
      tick(1);
      i++;
      if (toggle && !bus.frameDone) begin
        bus.frameReady = 1'($urandom_range(0, 1));
        bus.frameWords = ADDR_W'($urandom_range(0, 40));
      end
    end
    bus.frameReady = 1'b0;
    check("frame_done_seen", 32'(bus.frameDone), 1);
    check("byte_count", 32'(tx_count - tx_before), 2 * n + HDR);
    tick(1);
    check("done_pulse_width", 32'(bus.frameDone), 0);
    check("idle_after_done", 32'(bus.busy), 0);
    tick(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sraddr"}, 32'(bus.SRADDR), 0);
    check({tag, "_sroe_n"}, 32'(bus.SROE_N), 1);
    check({tag, "_srwe_n"}, 32'(bus.SRWE_N), 1);
    check({tag, "_readdata"}, 32'(bus.readData), 0);
    check({tag, "_txstart"}, 32'(bus.txStart), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_framedone"}, 32'(bus.frameDone), 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int oe_before;
    int seen;
    logic found;
    logic [7:0] rd_before;

    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    bus.frameReady = 1'b0;
    bus.frameWords = '0;
    #1 readRst_n = 1'b0;
    #2 check_reset_outputs("reset");
    tick(2);
    readRst_n = 1'b1;
    tick(2);

    // 1: three words, high byte first, latency from accept and OE.
    mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC;
    uart_len = 10;
    start_frame(3);
`ifndef FRAME_HEADER_EN
    check("oe_high_at_accept", 32'(bus.SROE_N), 1);
    tick(1);
    check("oe_low_after_accept", 32'(bus.SROE_N), 0);
    c0 = cyc;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      found = bus.txStart;
    end
    check("first_tx_seen", 32'(found), 1);
    check("first_tx_latency", 32'(cyc - c0), RD_WAIT + 1);
`endif
    finish_frame(3, 1'b0);

    // 2: transmitter held busy; nothing may be sent until it frees up.
    mem[0] = 16'hC0DE; mem[1] = 16'h4711;
    rd_before = bus.readData;
    hold_busy = 1'b1;
    start_frame(2);
    tick(50);
    check("no_tx_while_busy", 32'(tx_count - tx_before), 0);
    check("readdata_held", 32'(bus.readData), 32'(rd_before));
    hold_busy = 1'b0;
    tick(1);
    check("first_pulse_after_release", 32'(bus.txStart), 1);
    finish_frame(2, 1'b0);

    // 3: empty frame.
    oe_before = oe_low_count;
    start_frame(0);
`ifndef FRAME_HEADER_EN
    check("done_after_accept", 32'(bus.frameDone), 1);
`endif
    finish_frame(0, 1'b0);
    check("no_sram_access_empty", 32'(oe_low_count - oe_before), 0);

    // 4: reset after the third byte aborts, then a fresh frame starts at word 0.
    mem[0] = 16'hA1B2; mem[1] = 16'hC3D4; mem[2] = 16'hE5F6;
    start_frame(3);
    seen = 0;
    for (int i = 0; i < 3000 && seen < 3; i++) begin
      tick(1);
      if (bus.txStart) seen++;
    end
    check("third_byte_reached", 32'(seen), 3);
    #2 readRst_n = 1'b0;
    #1 check_reset_outputs("abort");
    exp_q.delete();
    tick(2);
    readRst_n = 1'b1;
    tick(2);
    start_frame(3);
    finish_frame(3, 1'b0);

    // 5: frameReady/frameWords wiggled mid-frame are ignored.
    for (int w = 0; w < 4; w++) mem[w] = 16'($urandom);
    start_frame(4);
    finish_frame(4, 1'b1);

    // 6: single word BEEF (header bytes expected when the header build is selected).
    mem[0] = 16'hBEEF;
    start_frame(1);
    finish_frame(1, 1'b0);

    // Randomized frames and transmitter speeds.
    for (int f = 0; f < 10; f++) begin
      int unsigned n;
      n = $urandom_range(1, 6);
      uart_len = $urandom_range(1, 12);
      for (int w = 0; w < int'(n); w++) mem[w] = 16'($urandom);
      start_frame(n);
      finish_frame(n, f[0]);
    end

    check("srwe_n_const", 32'(bus.SRWE_N), 1);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
